cam_masked_pri: RTL and testbench

- Parametrised successor to the team's 16x8 CAM.
- Entries carry valid bits. Search is masked (don't-care bits), has a one-cycle registered latency and a valid strobe, and reports lowest-index priority hit plus a multi-hit flag.
- Supports write, single-entry invalidate and full flush.
- Sits between lookup clients (address/tag match) and the control path that maintains entries.

---
 rtl/cam_pkg.sv | 22 ++
 rtl/cam_prio_enc.sv | 38 +++
 rtl/cam_masked_pri.sv | 131 +++++++++++++
 tb/tb_cam_masked_pri.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and helpers for the masked priority CAM
//
// Purpose : per-entry update operation encoding and index-width helper.
// Contents: cam_op_e    - update applied to one entry on a clock edge
//           calc_addr_w - index width for a given depth, never below 1 bit
package cam_pkg;

    // Update selected for one entry in one cycle. When several requests
    // hit the same entry, the highest-priority one is chosen:
    // flush over write over invalidate.
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_FLUSH = 2'd1,
        OP_WRITE = 2'd2,
        OP_INV   = 2'd3
    } cam_op_e;

    function automatic int calc_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// rtl/cam_prio_enc.sv - lowest-index priority encoder with multi-hit detect
//
// Purpose : reduce a per-entry match vector to hit / multi-hit / lowest index.
// Ports   : i_match - one bit per entry, 1 = entry matched
//           o_any   - at least one bit of i_match set
//           o_multi - two or more bits of i_match set
//           o_idx   - index of the lowest set bit, 0 when none set
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = calc_addr_w(DEPTH)
) (
    input  logic [DEPTH-1:0]  i_match,
    output logic              o_any,
    output logic              o_multi,
    output logic [ADDR_W-1:0] o_idx
);

    // Scan upward: the first set bit fixes the index, any later set bit
    // raises multi-hit.
    always_comb begin
        o_any   = 1'b0;
        o_multi = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_match[i]) begin
                if (o_any) begin
                    o_multi = 1'b1;
                end else begin
                    o_idx = ADDR_W'(i);
                end
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_masked_pri.sv
// rtl/cam_masked_pri.sv - masked-search CAM with valid bits and priority hit
//
// Purpose : DEPTH x DATA_W content-addressable memory. Masked search with one
//           cycle registered latency, lowest-index hit and multi-hit flag.
//           Supports write, single-entry invalidate and full flush.
// Ports   : clk, rst_n         - clock, asynchronous active-low reset
//           wr_en/addr/data    - write entry and set its valid bit
//           inv_en/inv_addr    - clear one valid bit
//           flush              - clear all valid bits
//           srch_valid/data/mask - search request (mask 1 = compare bit)
//           rslt_valid         - result strobe, one cycle after request
//           found, multi_hit   - any / two-or-more valid entries matched
//           srch_addr          - lowest matching index, 0 when nothing found
//           entry_valid        - current per-entry valid bits
module cam_masked_pri
    import cam_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = calc_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic              flush,
    input  logic              srch_valid,
    input  logic [DATA_W-1:0] srch_data,
    input  logic [DATA_W-1:0] srch_mask,
    output logic              rslt_valid,
    output logic              found,
    output logic              multi_hit,
    output logic [ADDR_W-1:0] srch_addr,
    output logic [DEPTH-1:0]  entry_valid
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    logic              r_rslt_valid;
    logic              r_found;
    logic              r_multi_hit;
    logic [ADDR_W-1:0] r_srch_addr;

    cam_op_e           w_op [DEPTH];
    logic [DEPTH-1:0]  w_match;
    logic              w_any;
    logic              w_multi;
    logic [ADDR_W-1:0] w_idx;

    // Per-entry update select. Out-of-range addresses (non-power-of-two
    // DEPTH) never equal any entry index, so they fall through to OP_NONE.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_op[i] = OP_NONE;
            if (flush) begin
                w_op[i] = OP_FLUSH;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                w_op[i] = OP_WRITE;
            end else if (inv_en && (inv_addr == ADDR_W'(i))) begin
                w_op[i] = OP_INV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                case (w_op[i])
                    OP_FLUSH: r_valid[i] <= 1'b0;
                    OP_WRITE: begin
                        r_mem[i]   <= wr_data;
                        r_valid[i] <= 1'b1;
                    end
                    OP_INV:   r_valid[i] <= 1'b0;
                    default:  ;
                endcase
            end
        end
    end

    // Match against current (pre-update) contents: a search in the same
    // cycle as an update sees the old state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && (((r_mem[i] ^ srch_data) & srch_mask) == '0);
        end
    end

    cam_prio_enc #(
        .DEPTH (DEPTH)
    ) u_prio_enc (
        .i_match (w_match),
        .o_any   (w_any),
        .o_multi (w_multi),
        .o_idx   (w_idx)
    );

    // Result fields hold their last value between searches; only the
    // strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rslt_valid <= 1'b0;
            r_found      <= 1'b0;
            r_multi_hit  <= 1'b0;
            r_srch_addr  <= '0;
        end else begin
            r_rslt_valid <= srch_valid;
            if (srch_valid) begin
                r_found     <= w_any;
                r_multi_hit <= w_multi;
                r_srch_addr <= w_idx;
            end
        end
    end

    assign rslt_valid  = r_rslt_valid;
    assign found       = r_found;
    assign multi_hit   = r_multi_hit;
    assign srch_addr   = r_srch_addr;
    assign entry_valid = r_valid;

endmodule

// File: tb/tb_cam_masked_pri.sv
// tb/tb_cam_masked_pri.sv - self-checking bench for cam_masked_pri
module tb_cam_masked_pri;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              inv_en;
    logic [ADDR_W-1:0] inv_addr;
    logic              flush;
    logic              srch_valid;
    logic [DATA_W-1:0] srch_data;
    logic [DATA_W-1:0] srch_mask;
    logic              rslt_valid;
    logic              found;
    logic              multi_hit;
    logic [ADDR_W-1:0] srch_addr;
    logic [DEPTH-1:0]  entry_valid;

    int checks   = 0;
    int failures = 0;

    cam_masked_pri #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .inv_en      (inv_en),
        .inv_addr    (inv_addr),
        .flush       (flush),
        .srch_valid  (srch_valid),
        .srch_data   (srch_data),
        .srch_mask   (srch_mask),
        .rslt_valid  (rslt_valid),
        .found       (found),
        .multi_hit   (multi_hit),
        .srch_addr   (srch_addr),
        .entry_valid (entry_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays of contents and valid flags.
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic              m_valid [DEPTH];
    logic              e_rv, e_found, e_multi;
    logic [ADDR_W-1:0] e_addr;

    typedef struct {
        logic              wr_en;
        logic [ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0] wr_data;
        logic              inv_en;
        logic [ADDR_W-1:0] inv_addr;
        logic              flush;
        logic              sv;
        logic [DATA_W-1:0] sd;
        logic [DATA_W-1:0] sm;
        logic              x_rv;
        logic              x_found;
        logic              x_multi;
        logic [ADDR_W-1:0] x_addr;
        logic [DEPTH-1:0]  x_ev;
    } vec_t;

    vec_t tab [12];

    function automatic logic [DEPTH-1:0] model_ev();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        inv_en = 0; inv_addr = 0; flush = 0;
        srch_valid = 0; srch_data = 0; srch_mask = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_valid[i] = 1'b0;
        end
        e_rv = 0; e_found = 0; e_multi = 0; e_addr = '0;
    endtask

    // Evaluate the model on the current inputs, then clock the DUT once and
    // return #1 after the edge with inputs cleared.
    task automatic step();
        int cnt;
        int first;
        if (srch_valid) begin
            cnt = 0; first = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_valid[i] && (((m_mem[i] ^ srch_data) & srch_mask) == 0)) begin
                    if (cnt == 0) first = i;
                    cnt++;
                end
            end
            e_found = (cnt > 0);
            e_multi = (cnt >= 2);
            e_addr  = ADDR_W'(first);
        end
        e_rv = srch_valid;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else begin
            if (inv_en) m_valid[inv_addr] = 1'b0;
            if (wr_en) begin
                m_mem[wr_addr]   = wr_data;
                m_valid[wr_addr] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        clr_inputs();
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rslt_valid"}, 32'(rslt_valid), 32'(e_rv));
        check({tag, ".found"}, 32'(found), 32'(e_found));
        check({tag, ".multi_hit"}, 32'(multi_hit), 32'(e_multi));
        check({tag, ".srch_addr"}, 32'(srch_addr), 32'(e_addr));
        check({tag, ".entry_valid"}, 32'(entry_valid), 32'(model_ev()));
    endtask

    task automatic search(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        srch_valid = 1; srch_data = d; srch_mask = m;
    endtask

    initial begin
        // wr   wa   wd     inv  ia   fl  sv  sd     sm     rv  f  m  addr ev
        tab[0]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'hFF, 1, 0, 0, 0, 16'h0000};
        tab[1]  = '{1, 3, 8'h5A, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0008};
        tab[2]  = '{1, 9, 8'h5A, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'h0208};
        tab[3]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hFF, 1, 1, 1, 3, 16'h0208};
        tab[4]  = '{0, 0, 8'h00, 1, 3, 0, 0, 8'h00, 8'h00, 0, 1, 1, 3, 16'h0200};
        tab[5]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h5A, 8'hFF, 1, 1, 0, 9, 16'h0200};
        tab[6]  = '{1, 5, 8'hA7, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 9, 16'h0220};
        tab[7]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'hA0, 8'hF0, 1, 1, 0, 5, 16'h0220};
        tab[8]  = '{0, 0, 8'h00, 0, 0, 0, 1, 8'hB0, 8'hF0, 1, 0, 0, 0, 16'h0220};
        tab[9]  = '{1, 2, 8'h33, 0, 0, 0, 1, 8'h33, 8'hFF, 1, 0, 0, 0, 16'h0224};
        tab[10] = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h33, 8'hFF, 1, 1, 0, 2, 16'h0224};
        tab[11] = '{0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 1, 1, 1, 2, 16'h0224};

        clr_inputs();
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        check_model("reset");

        // Directed table
        for (int k = 0; k < 12; k++) begin
            wr_en = tab[k].wr_en; wr_addr = tab[k].wr_addr; wr_data = tab[k].wr_data;
            inv_en = tab[k].inv_en; inv_addr = tab[k].inv_addr; flush = tab[k].flush;
            srch_valid = tab[k].sv; srch_data = tab[k].sd; srch_mask = tab[k].sm;
            step();
            check($sformatf("tab%0d.rslt_valid", k), 32'(rslt_valid), 32'(tab[k].x_rv));
            check($sformatf("tab%0d.found", k), 32'(found), 32'(tab[k].x_found));
            check($sformatf("tab%0d.multi_hit", k), 32'(multi_hit), 32'(tab[k].x_multi));
            check($sformatf("tab%0d.srch_addr", k), 32'(srch_addr), 32'(tab[k].x_addr));
            check($sformatf("tab%0d.entry_valid", k), 32'(entry_valid), 32'(tab[k].x_ev));
        end

        // Fill every entry with its index, then flush together with a write
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
            step();
        end
        check("fill.entry_valid", 32'(entry_valid), 32'h0000FFFF);
        flush = 1; wr_en = 1; wr_addr = 7; wr_data = 8'h77;
        step();
        check("flush_wr.entry_valid", 32'(entry_valid), 32'h00000000);
        search(8'h07, 8'hFF);
        step();
        check("flush_srch.rslt_valid", 32'(rslt_valid), 32'h1);
        check("flush_srch.found", 32'(found), 32'h0);
        wr_en = 1; wr_addr = 4; wr_data = 8'h44; inv_en = 1; inv_addr = 4;
        step();
        check("wr_inv.entry_valid", 32'(entry_valid), 32'h00000010);
        search(8'h44, 8'hFF);
        step();
        check("wr_inv_srch.found", 32'(found), 32'h1);
        check("wr_inv_srch.srch_addr", 32'(srch_addr), 32'h4);
        // Rewrite of a valid entry replaces its data
        wr_en = 1; wr_addr = 4; wr_data = 8'h45;
        step();
        search(8'h44, 8'hFF);
        step();
        check_model("rewrite_old");
        check("rewrite_old.found", 32'(found), 32'h0);

        // Reset pulse while a search is pending its result
        search(8'h01, 8'hFF);
        #1;
        rst_n = 0;
        srch_valid = 0;
        #1;
        check("rst_async.entry_valid", 32'(entry_valid), 32'h0);
        check("rst_async.rslt_valid", 32'(rslt_valid), 32'h0);
        #1;
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
        check_model("rst_mid");

        // Back-to-back searches, four consecutive result strobes
        wr_en = 1; wr_addr = 1; wr_data = 8'h01; step();
        wr_en = 1; wr_addr = 6; wr_data = 8'h81; step();
        for (int k = 0; k < 4; k++) begin
            search(8'h01, (k[0]) ? 8'h7F : 8'hFF);
            if (k == 3) search(8'h81, 8'hFF);
            step();
            check_model($sformatf("b2b%0d", k));
            check($sformatf("b2b%0d.strobe", k), 32'(rslt_valid), 32'h1);
        end
        step();
        check("b2b_idle.rslt_valid", 32'(rslt_valid), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data    = DATA_W'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
            inv_en     = ($urandom_range(0, 5) == 0);
            inv_addr   = ($urandom_range(0, 1) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
            flush      = ($urandom_range(0, 60) == 0);
            srch_valid = ($urandom_range(0, 3) != 0);
            srch_data  = DATA_W'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 8'hF0 : 8'h00);
            case ($urandom_range(0, 3))
                0:       srch_mask = 8'hFF;
                1:       srch_mask = 8'h00;
                default: srch_mask = DATA_W'($urandom);
            endcase
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
